// File: rtl/fir_regbank_pkg.sv
// Shared constants, state encoding and byte-merge helper for the FIR coefficient register bank.
package fir_regbank_pkg;

  localparam logic [7:0] SHADOW_BASE = 8'h00;
  localparam logic [7:0] ACTIVE_BASE = 8'h40;
  localparam logic [7:0] CTRL_ADR    = 8'h80;
  localparam logic [7:0] STATUS_ADR  = 8'h81;
  localparam logic [7:0] TESTVEC_ADR = 8'h82;
  localparam logic [7:0] ID_ADR      = 8'h83;

  localparam int unsigned CTRL_COMMIT_BIT    = 0;
  localparam int unsigned CTRL_ABORT_BIT     = 1;
  localparam int unsigned STATUS_PENDING_BIT = 0;
  localparam int unsigned STATUS_DIRTY_BIT   = 1;
  localparam int unsigned STATUS_CNT_LSB     = 8;

  localparam logic [7:0] ID_VERSION = 8'h01;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_state_e;

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_w,
                                              input logic [15:0] new_w,
                                              input logic [1:0]  sel);
    logic [15:0] res;
    res = old_w;
    if (sel[0]) res[7:0]  = new_w[7:0];
    if (sel[1]) res[15:8] = new_w[15:8];
    return res;
  endfunction

endpackage

// File: rtl/fir_coeff_commit_fsm.sv
// Commit sequencer: arms on a CTRL commit, fires the shadow->active swap on the next sample tick.
module fir_coeff_commit_fsm
  import fir_regbank_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       commit_i,
  input  logic       abort_i,
  input  logic       sample_tick_i,
  output logic       swap_o,
  output logic       pending_o,
  output logic       coeff_update_o,
  output logic [7:0] commit_cnt_o
);

  commit_state_e state_q;
  logic          coeff_update_q;
  logic [7:0]    commit_cnt_q;

  // A control write in the same cycle masks the tick, so a fresh commit waits for the next one.
  assign swap_o = (state_q == ST_PENDING) && sample_tick_i && !commit_i && !abort_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      coeff_update_q <= 1'b0;
      commit_cnt_q   <= '0;
    end else begin
      coeff_update_q <= 1'b0;
      if (abort_i) begin
        state_q <= ST_IDLE;
      end else if (commit_i) begin
        state_q <= ST_PENDING;
      end else if (swap_o) begin
        state_q        <= ST_IDLE;
        commit_cnt_q   <= commit_cnt_q + 8'd1;
        coeff_update_q <= 1'b1;
      end
    end
  end

  assign pending_o      = (state_q == ST_PENDING);
  assign coeff_update_o = coeff_update_q;
  assign commit_cnt_o   = commit_cnt_q;

endmodule

// File: rtl/fir_coeff_regbank.sv
// Wishbone coefficient register bank with atomic shadow->active commit.
// Define FIR_REGBANK_ERR_EN to answer unmapped / read-only writes with wb_err instead of wb_ack.
module fir_coeff_regbank
  import fir_regbank_pkg::*;
#(
  parameter int unsigned NUM_TAPS   = 33,
  parameter int unsigned COEFF_W    = 16,
  parameter logic [15:0] CENTER_RST = 16'hFFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    wb_adr,
  input  logic [15:0]                   wb_wr_dat,
  output logic [15:0]                   wb_rd_dat,
  input  logic                          wb_we,
  input  logic [1:0]                    wb_sel,
  input  logic                          wb_stb,
  input  logic                          wb_cyc,
  output logic                          wb_ack,
  output logic                          wb_err,
  input  logic                          sample_tick,
  output logic [NUM_TAPS*COEFF_W-1:0]   coeff,
  output logic                          coeff_update,
  output logic [15:0]                   testvec_sel
);

  localparam int unsigned  CENTER = NUM_TAPS / 2;
  localparam logic [7:0]   TAPS8  = 8'(NUM_TAPS);

  logic [COEFF_W-1:0] shadow_q [NUM_TAPS];
  logic [COEFF_W-1:0] shadow_d [NUM_TAPS];
  logic [COEFF_W-1:0] active_q [NUM_TAPS];
  logic [15:0]        testvec_q;
  logic               dirty_q;
  logic               dirty_set;
  logic               ack_q;
  logic               err_q;
  logic [15:0]        rd_dat_q;
  logic [15:0]        rd_word;
  logic [15:0]        old16;
  logic [15:0]        new16;

  logic               accept;
  logic [5:0]         tap_idx;
  logic               tap_ok;
  logic               in_shadow;
  logic               in_active;
  logic               shadow_wr;
  logic               ctrl_wr;
  logic               commit;
  logic               abort;
  logic               tv_wr;
  logic               swap;
  logic               pending;
  logic [7:0]         commit_cnt;

  assign accept    = wb_stb && wb_cyc && !ack_q && !err_q;
  assign tap_idx   = wb_adr[5:0];
  assign tap_ok    = ({26'd0, tap_idx} < NUM_TAPS);
  assign in_shadow = (wb_adr[7:6] == SHADOW_BASE[7:6]);
  assign in_active = (wb_adr[7:6] == ACTIVE_BASE[7:6]);
  assign shadow_wr = accept && wb_we && in_shadow && tap_ok;
  assign ctrl_wr   = accept && wb_we && (wb_adr == CTRL_ADR) && wb_sel[0];
  assign commit    = ctrl_wr && wb_wr_dat[CTRL_COMMIT_BIT];
  assign abort     = ctrl_wr && wb_wr_dat[CTRL_ABORT_BIT];
  assign tv_wr     = accept && wb_we && (wb_adr == TESTVEC_ADR);

  fir_coeff_commit_fsm u_fsm (
    .clk            (clk),
    .rst            (rst),
    .commit_i       (commit),
    .abort_i        (abort),
    .sample_tick_i  (sample_tick),
    .swap_o         (swap),
    .pending_o      (pending),
    .coeff_update_o (coeff_update),
    .commit_cnt_o   (commit_cnt)
  );

  // Byte-merge against the zero-extended stored value, then drop bits above COEFF_W.
  always_comb begin
    dirty_set = 1'b0;
    old16     = '0;
    new16     = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      shadow_d[k] = shadow_q[k];
      if (shadow_wr && ({26'd0, tap_idx} == k)) begin
        old16                = '0;
        old16[COEFF_W-1:0]   = shadow_q[k];
        new16                = merge_bytes(old16, wb_wr_dat, wb_sel);
        shadow_d[k]          = new16[COEFF_W-1:0];
        if (shadow_d[k] != shadow_q[k]) dirty_set = 1'b1;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (in_shadow && tap_ok) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++)
        if ({26'd0, tap_idx} == k) rd_word[COEFF_W-1:0] = shadow_q[k];
    end else if (in_active && tap_ok) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++)
        if ({26'd0, tap_idx} == k) rd_word[COEFF_W-1:0] = active_q[k];
    end else begin
      case (wb_adr)
        STATUS_ADR: begin
          rd_word[STATUS_PENDING_BIT]             = pending;
          rd_word[STATUS_DIRTY_BIT]               = dirty_q;
          rd_word[STATUS_CNT_LSB +: 8]            = commit_cnt;
        end
        TESTVEC_ADR: rd_word = testvec_q;
        ID_ADR:      rd_word = {ID_VERSION, TAPS8};
        default:     rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        shadow_q[k] <= (k == CENTER) ? CENTER_RST[COEFF_W-1:0] : '0;
        active_q[k] <= (k == CENTER) ? CENTER_RST[COEFF_W-1:0] : '0;
      end
      testvec_q <= '0;
      dirty_q   <= 1'b0;
    end else begin
      // Non-blocking copy takes the pre-write shadow when a write and swap coincide.
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        shadow_q[k] <= shadow_d[k];
        if (swap) active_q[k] <= shadow_q[k];
      end
      if (tv_wr) testvec_q <= merge_bytes(testvec_q, wb_wr_dat, wb_sel);
      if (dirty_set)  dirty_q <= 1'b1;
      else if (swap)  dirty_q <= 1'b0;
    end
  end

`ifdef FIR_REGBANK_ERR_EN
  logic bad;
  assign bad = !(((in_shadow || in_active) && tap_ok) ||
                 (wb_adr == CTRL_ADR) || (wb_adr == STATUS_ADR) ||
                 (wb_adr == TESTVEC_ADR) || (wb_adr == ID_ADR)) ||
               (wb_we && (in_active || (wb_adr == STATUS_ADR) || (wb_adr == ID_ADR)));

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      ack_q    <= accept && !bad;
      err_q    <= accept && bad;
      rd_dat_q <= (accept && !bad && !wb_we) ? rd_word : '0;
    end
  end
`else
  assign err_q = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      ack_q    <= accept;
      rd_dat_q <= (accept && !wb_we) ? rd_word : '0;
    end
  end
`endif

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_coeff
    assign coeff[k*COEFF_W +: COEFF_W] = active_q[k];
  end

  assign wb_ack      = ack_q;
  assign wb_err      = err_q;
  assign wb_rd_dat   = rd_dat_q;
  assign testvec_sel = testvec_q;

endmodule

// File: tb/tb_fir_coeff_regbank.sv
// Directed self-checking bench for fir_coeff_regbank (default parameters).
module tb_fir_coeff_regbank;

  localparam int unsigned NUM_TAPS = 33;
  localparam int unsigned COEFF_W  = 16;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [7:0]                  wb_adr;
  logic [15:0]                 wb_wr_dat;
  logic [15:0]                 wb_rd_dat;
  logic                        wb_we;
  logic [1:0]                  wb_sel;
  logic                        wb_stb;
  logic                        wb_cyc;
  logic                        wb_ack;
  logic                        wb_err;
  logic                        sample_tick;
  logic [NUM_TAPS*COEFF_W-1:0] coeff;
  logic                        coeff_update;
  logic [15:0]                 testvec_sel;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  fir_coeff_regbank #(.NUM_TAPS(NUM_TAPS), .COEFF_W(COEFF_W), .CENTER_RST(16'hFFFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_adr       (wb_adr),
    .wb_wr_dat    (wb_wr_dat),
    .wb_rd_dat    (wb_rd_dat),
    .wb_we        (wb_we),
    .wb_sel       (wb_sel),
    .wb_stb       (wb_stb),
    .wb_cyc       (wb_cyc),
    .wb_ack       (wb_ack),
    .wb_err       (wb_err),
    .sample_tick  (sample_tick),
    .coeff        (coeff),
    .coeff_update (coeff_update),
    .testvec_sel  (testvec_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (coeff_update) upd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] adr, input logic we, input logic [15:0] dat,
                      input logic [1:0] sel, input logic tick,
                      output logic [15:0] rdat, output logic acked, output logic erred);
    @(negedge clk);
    wb_adr = adr; wb_we = we; wb_wr_dat = dat; wb_sel = sel;
    wb_stb = 1'b1; wb_cyc = 1'b1; sample_tick = tick;
    @(negedge clk);
    rdat = wb_rd_dat; acked = wb_ack; erred = wb_err;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; sample_tick = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [7:0] adr, input logic [15:0] dat,
                    input logic [1:0] sel, input logic tick);
    logic [15:0] d; logic a; logic e;
    xfer(adr, 1'b1, dat, sel, tick, d, a, e);
    check({tag, ".ack"}, {16'd0, a, e, d[13:0]}, {16'd0, 2'b10, 14'd0});
  endtask

  task automatic rd(input string tag, input logic [7:0] adr, input logic [15:0] exp);
    logic [15:0] d; logic a; logic e;
    xfer(adr, 1'b0, 16'h0, 2'b11, 1'b0, d, a, e);
    check(tag, {14'd0, a, e, d}, {14'd0, 2'b10, exp});
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); sample_tick = 1'b1;
      @(negedge clk); sample_tick = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [15:0] d; logic a; logic e;
    int          u0;
    rst = 1'b1; wb_adr = '0; wb_wr_dat = '0; wb_we = 1'b0; wb_sel = '0;
    wb_stb = 1'b0; wb_cyc = 1'b0; sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst.outs", {28'd0, wb_ack, wb_err, coeff_update, |wb_rd_dat}, 32'd0);
    check("rst.tap16", {16'd0, coeff[16*16 +: 16]}, 32'h0000FFFF);
    check("rst.tap0",  {16'd0, coeff[0 +: 16]}, 32'h0);
    check("rst.tv",    {16'd0, testvec_sel}, 32'h0);
    rd("rst.sh16", 8'h10, 16'hFFFF);
    rd("rst.ac16", 8'h50, 16'hFFFF);
    rd("rst.sh0",  8'h00, 16'h0000);
    rd("rst.id",   8'h83, 16'h0121);
    rd("rst.stat", 8'h81, 16'h0000);

    // basic commit
    wr("w05", 8'h05, 16'h1234, 2'b11, 1'b0);
    wr("commit1", 8'h80, 16'h0001, 2'b11, 1'b0);
    rd("ac5.pre", 8'h45, 16'h0000);
    rd("stat.pend", 8'h81, 16'h0003);
    rd("ctrl.rd0", 8'h80, 16'h0000);
    u0 = upd_cnt;
    tick_n(1);
    check("upd.one", upd_cnt - u0, 1);
    check("coeff5", {16'd0, coeff[5*16 +: 16]}, 32'h1234);
    rd("ac5.post", 8'h45, 16'h1234);
    rd("stat.c1", 8'h81, 16'h0100);

    // byte enables
    wr("w07.sel", 8'h07, 16'hABCD, 2'b01, 1'b0);
    rd("sh7", 8'h07, 16'h00CD);
    rd("stat.dirty", 8'h81, 16'h0102);

    // commit then abort, and commit+abort in one write
    wr("commit2", 8'h80, 16'h0001, 2'b11, 1'b0);
    wr("abort", 8'h80, 16'h0002, 2'b11, 1'b0);
    u0 = upd_cnt;
    tick_n(5);
    check("abort.noupd", upd_cnt - u0, 0);
    rd("abort.ac7", 8'h47, 16'h0000);
    rd("abort.stat", 8'h81, 16'h0102);
    wr("comab", 8'h80, 16'h0003, 2'b11, 1'b0);
    rd("comab.stat", 8'h81, 16'h0102);

    // shadow write coinciding with the swap tick
    wr("commit3", 8'h80, 16'h0001, 2'b11, 1'b0);
    u0 = upd_cnt;
    wr("w03.tick", 8'h03, 16'h5555, 2'b11, 1'b1);
    repeat (2) @(negedge clk);
    check("coin.upd", upd_cnt - u0, 1);
    rd("coin.ac3", 8'h43, 16'h0000);
    rd("coin.sh3", 8'h03, 16'h5555);
    rd("coin.ac7", 8'h47, 16'h00CD);
    rd("coin.stat", 8'h81, 16'h0202);

    // tick in the commit-accept cycle is not a commit point
    wr("commit.tick", 8'h80, 16'h0001, 2'b11, 1'b1);
    rd("ct.stat", 8'h81, 16'h0203);
    rd("ct.ac3", 8'h43, 16'h0000);
    tick_n(1);
    rd("ct.ac3b", 8'h43, 16'h5555);
    rd("ct.stat2", 8'h81, 16'h0300);

    // unmapped / read-only accesses
    xfer(8'h30, 1'b0, 16'h0, 2'b11, 1'b0, d, a, e);
`ifdef FIR_REGBANK_ERR_EN
    check("unm.rd", {14'd0, a, e, d}, {14'd0, 2'b01, 16'h0});
`else
    check("unm.rd", {14'd0, a, e, d}, {14'd0, 2'b10, 16'h0});
`endif
    xfer(8'h40, 1'b1, 16'hBEEF, 2'b11, 1'b0, d, a, e);
`ifdef FIR_REGBANK_ERR_EN
    check("ro.wr", {14'd0, a, e, d}, {14'd0, 2'b01, 16'h0});
`else
    check("ro.wr", {14'd0, a, e, d}, {14'd0, 2'b10, 16'h0});
`endif
    rd("ro.ac0", 8'h40, 16'h0000);
    rd("ro.stat", 8'h81, 16'h0300);
    wr("w20", 8'h20, 16'h7777, 2'b11, 1'b0);
    rd("sh32", 8'h20, 16'h7777);
    rd("stat.d2", 8'h81, 16'h0302);

    // back-to-back reads: ack every second cycle
    @(negedge clk);
    wb_adr = 8'h83; wb_we = 1'b0; wb_sel = 2'b11; wb_stb = 1'b1; wb_cyc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("b2b.%0d", i), {15'd0, wb_ack, wb_rd_dat},
            (i % 2 == 0) ? {15'd0, 1'b1, 16'h0121} : 32'd0);
    end
    wb_stb = 1'b0; wb_cyc = 1'b0;
    @(negedge clk);

    // test vector register with byte enables
    wr("tv.w", 8'h82, 16'hA5A5, 2'b11, 1'b0);
    check("tv.out", {16'd0, testvec_sel}, 32'h0000A5A5);
    wr("tv.hi", 8'h82, 16'h1200, 2'b10, 1'b0);
    rd("tv.rd", 8'h82, 16'h12A5);

    // reset during PENDING drops the commit
    wr("commit4", 8'h80, 16'h0001, 2'b11, 1'b0);
    rd("p4.stat", 8'h81, 16'h0303);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0;
    u0 = upd_cnt;
    tick_n(2);
    check("rstp.upd", upd_cnt - u0, 0);
    check("rstp.tv", {16'd0, testvec_sel}, 32'h0);
    rd("rstp.stat", 8'h81, 16'h0000);
    rd("rstp.sh32", 8'h20, 16'h0000);
    rd("rstp.ac5", 8'h45, 16'h0000);
    rd("rstp.ac16", 8'h50, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
